// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write port bundle
// for the program loader.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 5
);
   logic                  byte_valid;
   logic [7:0]            byte_data;
   logic                  byte_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;

   modport master (
      output byte_valid, byte_data,
      input  byte_ready,
      input  mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready,
      output mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Program loader: packs a byte stream into little-endian
// words and writes them to instruction memory.
module imem_loader #(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_WIDTH:0] num_words,
   input  logic                abort,
   imem_loader_if.slave        bus,
   output logic                core_hold,
   output logic                busy,
   output logic                done,
   output logic                err
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      WRITE,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] last_q, last_d;
   logic [1:0]            idx_q, idx_d;
   logic [31:0]           word_q, word_d;
   logic                  err_q, err_d;
   logic                  loaded_q, loaded_d;
   logic [ADDR_WIDTH:0]   nw_m1;

   assign nw_m1 = num_words - 1'b1;

   // state and datapath registers, synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         last_q   <= '0;
         idx_q    <= '0;
         word_q   <= '0;
         err_q    <= 1'b0;
         loaded_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         last_q   <= last_d;
         idx_q    <= idx_d;
         word_q   <= word_d;
         err_q    <= err_d;
         loaded_q <= loaded_d;
      end
   end

   // next-state logic; abort wins over byte acceptance
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      last_d   = last_q;
      idx_d    = idx_q;
      word_d   = word_q;
      err_d    = err_q;
      loaded_d = loaded_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               loaded_d = 1'b0;
               if (num_words == '0) begin
                  state_d = DONE;
               end else if (int'(num_words) > DEPTH) begin
                  err_d = 1'b1;
               end else begin
                  last_d  = nw_m1[ADDR_WIDTH-1:0];
                  addr_d  = '0;
                  idx_d   = '0;
                  err_d   = 1'b0;
                  state_d = RECV;
               end
            end
         end
         RECV: begin
            if (abort) begin
               err_d   = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end else if (bus.byte_valid) begin
               word_d[{idx_q, 3'b000} +: 8] = bus.byte_data;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = WRITE;
            end
         end
         WRITE: begin
            if (abort) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (addr_q == last_q) begin
               state_d = DONE;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = RECV;
            end
         end
         DONE: begin
            loaded_d = 1'b1;
            state_d  = IDLE;
         end
      endcase
   end

   // outputs decoded straight from registered state
   assign bus.byte_ready = (state_q == RECV);
   assign bus.mem_we     = (state_q == WRITE);
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = word_q;
   assign busy           = (state_q != IDLE);
   assign done           = (state_q == DONE);
   assign err            = err_q;
   assign core_hold      = !loaded_q | busy;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, stalls,
// size limits, abort and mid-load reset.
module tb_imem_loader;
   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic [5:0] num_words;
   logic       abort;
   logic       core_hold, busy, done, err;

   int checks = 0;
   int errors = 0;
   int wcount = 0;
   int dcount = 0;
   logic [31:0] mem [32];

   imem_loader_if #(.ADDR_WIDTH(5)) bus ();

   imem_loader #(.ADDR_WIDTH(5)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .num_words (num_words),
      .abort     (abort),
      .bus       (bus.slave),
      .core_hold (core_hold),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (reset && bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
         wcount <= wcount + 1;
      end
      if (reset && done) dcount <= dcount + 1;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic ok;
      ok = 1'b0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      for (int i = 0; i < 16 && !ok; i++) begin
         ok = bus.byte_ready;
         tick();
      end
      bus.byte_valid = 1'b0;
      chk("byte_accept", {31'd0, ok}, 32'd1);
   endtask

   // leaves the bench in the WRITE cycle of this word
   task automatic send_word(input logic [31:0] w,
                            input logic [4:0] a);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
      chk("we", {31'd0, bus.mem_we}, 32'd1);
      chk("addr", {27'd0, bus.mem_addr}, {27'd0, a});
      chk("wdata", bus.mem_wdata, w);
   endtask

   initial begin
      int w0, d0;
      logic [31:0] w;
      reset = 1'b0;
      start = 1'b0;
      num_words = '0;
      abort = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data = '0;
      tick();
      tick();
      chk("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
      chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_addr", {27'd0, bus.mem_addr}, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      chk("rst_flags", {28'd0, busy, done, err, core_hold}, 32'd1);
      reset = 1'b1;
      tick();

      // two-word load
      start = 1'b1;
      num_words = 6'd2;
      tick();
      start = 1'b0;
      chk("t1_busy", {30'd0, busy, core_hold}, 32'd3);
      send_word(32'h00100013, 5'd0);
      tick();
      send_word(32'h00200093, 5'd1);
      tick();
      chk("t1_done", {30'd0, done, core_hold}, 32'd3);
      tick();
      chk("t1_after", {29'd0, done, busy, core_hold}, 32'd0);
      chk("t1_mem0", mem[0], 32'h00100013);
      chk("t1_mem1", mem[1], 32'h00200093);
      chk("t1_dcnt", dcount, 32'd1);

      // stall mid-word
      start = 1'b1;
      num_words = 6'd1;
      tick();
      start = 1'b0;
      send_byte(8'h37);
      send_byte(8'h05);
      for (int i = 0; i < 3; i++) begin
         chk("t2_stall", {30'd0, bus.byte_ready, bus.mem_we}, 32'd2);
         tick();
      end
      send_byte(8'h01);
      send_byte(8'h00);
      chk("t2_we", {31'd0, bus.mem_we}, 32'd1);
      chk("t2_wdata", bus.mem_wdata, 32'h00010537);
      tick();
      tick();

      // zero words, then too many words
      w0 = wcount;
      start = 1'b1;
      num_words = 6'd0;
      tick();
      start = 1'b0;
      chk("t3_zero_done", {30'd0, done, bus.mem_we}, 32'd2);
      tick();
      chk("t3_zero_hold", {31'd0, core_hold}, 32'd0);
      start = 1'b1;
      num_words = 6'd33;
      tick();
      start = 1'b0;
      chk("t3_big", {29'd0, err, busy, core_hold}, 32'd5);
      tick();
      chk("t3_nowrite", wcount - w0, 32'd0);

      // full 32-word load
      d0 = dcount;
      start = 1'b1;
      num_words = 6'd32;
      tick();
      start = 1'b0;
      chk("t4_errclr", {31'd0, err}, 32'd0);
      for (int i = 0; i < 32; i++) begin
         w = {8'h5A, 8'hA5, 8'(i + 1), 8'(i)};
         send_word(w, 5'(i));
         tick();
      end
      chk("t4_done", {31'd0, done}, 32'd1);
      tick();
      chk("t4_mem31", mem[31], 32'h5AA5201F);
      chk("t4_dcnt", dcount - d0, 32'd1);
      chk("t4_idle", {30'd0, busy, core_hold}, 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("idle_abort", {30'd0, err, core_hold}, 32'd0);

      // abort inside the second word
      w0 = wcount;
      d0 = dcount;
      start = 1'b1;
      num_words = 6'd3;
      tick();
      start = 1'b0;
      send_word(32'h11223344, 5'd0);
      tick();
      send_byte(8'hEE);
      send_byte(8'hDD);
      abort = 1'b1;
      bus.byte_valid = 1'b1;
      tick();
      abort = 1'b0;
      bus.byte_valid = 1'b0;
      chk("t5_abort", {28'd0, busy, done, err, core_hold}, 32'd3);
      tick();
      chk("t5_wcnt", wcount - w0, 32'd1);
      chk("t5_mem0", mem[0], 32'h11223344);
      chk("t5_mem1", mem[1], 32'h5AA50201);
      chk("t5_dcnt", dcount - d0, 32'd0);
      start = 1'b1;
      num_words = 6'd1;
      tick();
      start = 1'b0;
      chk("t5_errclr", {31'd0, err}, 32'd0);

      // reset during WRITE
      send_word(32'hCAFEF00D, 5'd0);
      reset = 1'b0;
      tick();
      chk("t6_we", {31'd0, bus.mem_we}, 32'd0);
      chk("t6_addr", {27'd0, bus.mem_addr}, 32'd0);
      chk("t6_wdata", bus.mem_wdata, 32'd0);
      chk("t6_flags", {28'd0, busy, done, err, core_hold}, 32'd1);
      reset = 1'b1;
      tick();

      // start while busy is ignored
      start = 1'b1;
      num_words = 6'd2;
      tick();
      num_words = 6'd0;
      send_word(32'h00000013, 5'd0);
      tick();
      chk("t6_busy_start", {30'd0, bus.byte_ready, done}, 32'd2);
      send_word(32'h00000073, 5'd1);
      start = 1'b0;
      tick();
      chk("t6_done", {31'd0, done}, 32'd1);
      tick();
      chk("t6_loaded", {31'd0, core_hold}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
